// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
// The attached 2-bit counter signals carry while counting through CNT_CARRY_VAL.
package counter_seq_ctrl_pkg;

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_CARRY_VAL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_RELOAD = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_round_cnt.sv
// Completed-round counter: synchronous clear on job accept, increment per carry.
module ctrl_round_cnt
    import counter_seq_ctrl_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [RW-1:0] o_cnt
);

    logic [RW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + RW'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequences an external 2-bit loadable counter through a programmed number of
// carry rounds, with host start/done handshake, pause and synchronous abort.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] init_val,
    input  logic [RW-1:0]    rounds,
    input  logic             pause,
    input  logic             abort,
    input  logic             cnt_cout,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_in,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    round_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_init;
    logic [RW-1:0]    r_rounds;
    logic             w_accept;
    logic             w_clr;
    logic             w_inc;
    logic [RW-1:0]    w_round_nxt;

    assign w_round_nxt = round_cnt + RW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init   <= '0;
            r_rounds <= '0;
        end else if (w_accept) begin
            r_init   <= init_val;
            r_rounds <= rounds;
        end
    end

    // abort outranks everything, including a carry that would finish the job
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clr    = 1'b0;
        w_inc    = 1'b0;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_accept = 1'b1;
                        w_clr    = 1'b1;
                        w_next   = ST_LOAD;
                    end
                end
                ST_LOAD:   w_next = (r_rounds == '0) ? ST_DONE : ST_RUN;
                ST_RUN: begin
                    if (cnt_cout) begin
                        w_inc  = 1'b1;
                        w_next = (w_round_nxt == r_rounds) ? ST_DONE : ST_RELOAD;
                    end
                end
                ST_RELOAD: w_next = ST_RUN;
                ST_DONE:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    ctrl_round_cnt #(.RW(RW)) u_round_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_inc (w_inc),
        .o_cnt (round_cnt)
    );

    // RELOAD reloads over the counter's post-carry value
    assign cnt_load    = (r_state == ST_LOAD) || (r_state == ST_RELOAD);
    assign cnt_en      = (r_state == ST_RUN) && !pause;
    assign cnt_load_in = r_init;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench: each job's expected outcome is queued at issue time and
// checked by an independent monitor when busy falls.
module tb_counter_seq_ctrl;
    import counter_seq_ctrl_pkg::*;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset, start, pause, abort, cnt_cout;
    logic [1:0]    init_val;
    logic [RW-1:0] rounds;
    logic          cnt_load, cnt_en, busy, done;
    logic [1:0]    cnt_load_in;
    logic [RW-1:0] round_cnt;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .init_val(init_val),
        .rounds(rounds), .pause(pause), .abort(abort), .cnt_cout(cnt_cout),
        .cnt_load(cnt_load), .cnt_load_in(cnt_load_in), .cnt_en(cnt_en),
        .busy(busy), .done(done), .round_cnt(round_cnt)
    );

    // attached counter: carries while counting through value 2
    logic [1:0] q = 2'd0;
    always @(posedge clk) begin
        if (cnt_load)
            q <= cnt_load_in;
        else if (cnt_en)
            q <= q + 2'd1;
    end
    assign cnt_cout = cnt_en && (q == CNT_CARRY_VAL);

    typedef struct {
        int len;
        int en;
        int done_at;
        int rc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cur_init = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor
    initial begin
        int   m_len, m_en, m_done_at;
        bit   prev_busy;
        exp_t e;
        prev_busy = 0;
        m_len = 0; m_en = 0; m_done_at = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 0;
            end else begin
                if (busy) begin
                    if (!prev_busy) begin
                        m_len = 0; m_en = 0; m_done_at = 0;
                    end
                    m_len++;
                    if (cnt_en) m_en++;
                    if (done) m_done_at = (m_done_at == 0) ? m_len : -1;
                    chk("load_en_exclusive", int'(cnt_load && cnt_en), 0);
                    if (cnt_load) chk("load_value", int'(cnt_load_in), cur_init);
                end else begin
                    chk("idle_outputs", int'({done, cnt_en, cnt_load}), 0);
                end
                if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("job_len", m_len, e.len);
                        chk("en_cycles", m_en, e.en);
                        chk("done_cycle", m_done_at, e.done_at);
                        chk("round_cnt", int'(round_cnt), e.rc);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    // pmode: 0 none, 1 random, 2 fixed window in cycles 5..9
    // abort_at: 0 none, -1 final carry cycle, -2 random cycle, else that cycle
    task automatic run_job(input int init, input int rnds, input int pmode,
                           input int abort_at, input bit spur);
        bit   pat[512];
        bit   run_c[512];
        bit   car[512];
        int   L, t, rem, len, a, lim;
        exp_t e;
        L = ((2 - init + 4) % 4) + 1;
        for (int i = 0; i < 512; i++) begin
            pat[i]   = (pmode == 1) ? ($urandom_range(0, 3) == 0) :
                       (pmode == 2) ? (i >= 5 && i <= 9) : 1'b0;
            run_c[i] = 0;
            car[i]   = 0;
        end
        // cycle 1 is LOAD; each round is L unpaused counting cycles, reload between rounds
        t = 2;
        for (int r = 0; r < rnds; r++) begin
            rem = L;
            while (rem > 0 && t < 500) begin
                run_c[t] = 1;
                if (!pat[t]) begin
                    rem--;
                    if (rem == 0) car[t] = 1;
                end
                t++;
            end
            if (r < rnds - 1) t++;
        end
        len = t;
        a = (abort_at == -1) ? len - 1 :
            (abort_at == -2) ? $urandom_range(1, len - 1) : abort_at;
        if (a > 0) begin
            e.len = a; e.done_at = 0; e.en = 0; e.rc = 0;
            for (int i = 1; i <= a; i++) if (run_c[i] && !pat[i]) e.en++;
            for (int i = 1; i < a; i++) if (car[i]) e.rc++;
        end else begin
            e.len = len; e.done_at = len; e.en = rnds * L; e.rc = rnds;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        cur_init = init;
        init_val = 2'(init);
        rounds   = RW'(rnds);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        init_val = 2'($urandom);
        rounds   = RW'($urandom);
        lim = (a > 0) ? a : len;
        for (int c = 1; c <= len + 1; c++) begin
            pause = (c < 512) ? pat[c] : 1'b0;
            abort = (c == a);
            start = spur && (c >= 2) && (c < lim) && ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
        end
        pause = 0; abort = 0; start = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        reset = 1; start = 0; pause = 0; abort = 0; init_val = 0; rounds = 0;
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_en", int'(cnt_en), 0);
        chk("rst_load", int'(cnt_load), 0);
        chk("rst_round_cnt", int'(round_cnt), 0);
        chk("rst_load_in", int'(cnt_load_in), 0);
        @(posedge clk); #1;
        reset = 0;

        run_job(0, 2, 0, 0, 0);
        run_job(3, 1, 0, 0, 0);
        run_job(2, 0, 0, 0, 0);
        run_job(1, 3, 2, 0, 0);
        run_job(0, 2, 0, -1, 0);

        // asynchronous reset mid-RUN: init 1 gives first carry in cycle 3
        @(posedge clk); #1;
        cur_init = 1; init_val = 2'd1; rounds = RW'(5); start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_round_cnt", int'(round_cnt), 1);
        chk("pre_reset_busy", int'(busy), 1);
        #1;
        reset = 1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_en", int'(cnt_en), 0);
        chk("async_round_cnt", int'(round_cnt), 0);
        chk("async_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 0;

        run_job(2, 3, 0, 0, 1);
        run_job(3, 15, 1, 0, 1);
        for (int k = 0; k < 30; k++)
            run_job($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1),
                    ($urandom_range(0, 4) == 0) ? -2 : 0, 1'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("final_idle", int'(busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- FSM controller that sequences an external 2-bit loadable up-counter (load/enable/carry interface) through a programmable number of count rounds.
- Each round: load counter with a start value, enable until the counter's carry-out, then reload.
- Reports progress and signals completion to a host with a start/done handshake.
- Sits between host control logic and the counter datapath; the counter's own reset is not driven by this block.

Parameters:
- RW, 4, width of the round-count input and the round counter; max rounds 2^RW-1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
- start  in  1  host request; sampled only in IDLE.
- init_val  in  2  counter start value; latched on an accepted start.
- rounds  in  RW  number of carry events to run; latched on an accepted start.
- pause  in  1  while high in RUN, counter enable is held low.
- abort  in  1  synchronous cancel; any state goes to IDLE next edge, no done.
- cnt_cout  in  1  carry-out from the counter.
- cnt_load  out  1  counter load strobe.
- cnt_load_in  out  2  counter load value; always equals latched init_val.
- cnt_en  out  1  counter enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- round_cnt  out  RW  completed rounds in the current job.

Behaviour:
- Reset values: state IDLE; cnt_load=0, cnt_en=0, busy=0, done=0, round_cnt=0; latched init_val=0 and rounds=0.
- All outputs are registered-state decodes (Moore). cnt_load and cnt_en are never both high.
- IDLE:
  - start=1 latches init_val and rounds, clears round_cnt, then goes to LOAD.
  - start in any other state is ignored.
- LOAD: cnt_load=1.
  - If latched rounds=0, go to DONE (no counting).
  - Otherwise go to RUN.
- RUN: cnt_en = ~pause.
  - On cnt_cout=1, round_cnt increments.
  - If the new round_cnt equals latched rounds, go to DONE; otherwise go to RELOAD.
  - cnt_cout is ignored outside RUN.
- RELOAD: cnt_load=1, which overrides the counter's post-carry value of 3; then go to RUN.
- DONE: done=1 for exactly one cycle, busy=1; then go to IDLE. round_cnt holds its final value until the next accepted start.
- Round length: enabled RUN cycles per round = ((2 - init_val) mod 4) + 1.
  - init 0: 3 cycles. init 1: 2. init 2: 1. init 3: 4.
- pause: freezes the counter. It does not change state or round_cnt. pause held indefinitely keeps the block in RUN.
- abort priority: abort > cnt_cout > pause.
  - abort coincident with a final carry gives IDLE and no done.
  - round_cnt keeps its value at abort.
- reset mid-job: immediate IDLE, outputs at reset values, latched job discarded.
- round_cnt never wraps: the terminal compare occurs at or before 2^RW-1.

Decomposition:
- Shared package holds:
  - state typedef with encodings ST_IDLE=0, ST_LOAD=1, ST_RUN=2, ST_RELOAD=3, ST_DONE=4 (3-bit);
  - constant CNT_W=2;
  - constant CNT_CARRY_VAL=2'b10.
- One natural sub-module: ctrl_round_cnt, an RW-bit up counter with synchronous clear and increment enable and asynchronous reset. It is instantiated once for round_cnt.

Test Plan:
- init_val=0, rounds=2, start pulsed at edge E0, counter model attached.
  - Required: LOAD in cycle 1; RUN cycles 2-4 with carry in cycle 4; RELOAD cycle 5; RUN 6-8; done=1 only in cycle 9.
  - round_cnt reads 1 then 2; busy low from cycle 10.
- init_val=3, rounds=1.
  - Required: 4 enabled RUN cycles (3,0,1,2), then DONE.
  - cnt_load never coincides with cnt_en.
- rounds=0.
  - Required: LOAD then DONE; done high in cycle 2; cnt_en never asserted; round_cnt=0.
- init_val=1, rounds=3, pause high for 5 cycles mid-RUN in round 2.
  - Required: cnt_en low and counter frozen for those 5 cycles; total job length extended by exactly 5; done still pulses once; round_cnt=3.
- abort asserted in the same cycle as the final cnt_cout (rounds=2).
  - Required: IDLE next cycle; done never pulses; round_cnt=1.
- reset asserted asynchronously mid-RUN.
  - Required: busy, cnt_en and round_cnt go to 0 without waiting for a clock edge.
  - A new start after release runs a full job correctly; a start pulsed while busy is ignored.
